pipeline_sequencer: RTL
=======================

# pipeline_sequencer

Central control block for the four-stage BRISC pipeline (fetch/decode, data, execute, writeback). It holds the pipeline idle until the UART program load completes. It inserts a one-cycle bubble on register read-after-write hazards and flushes the two younger stages on a taken jump. It also supports single-step debug from a switch and a push-button, and counts retired instructions for display.

## Interface
Parameters:
- REG_ADDR_W, 4, register-file address width
- CNT_W, 16, retired-instruction counter width

Ports:
- CLK  in  1  system clock; the only clock
- RST_N  in  1  reset, asynchronous assert, active-low
- load_done  in  1  level; instruction memory holds a complete program
- step_mode  in  1  level (switch); 1 = single-step debug
- step_btn  in  1  raw asynchronous push-button
- jump_en_E  in  1  taken jump resolved in execute stage
- reg_write_E  in  1  execute-stage instruction writes the register file
- c_addr_E  in  REG_ADDR_W  destination register of execute-stage instruction
- a_addr_D, b_addr_D  in  REG_ADDR_W  source registers of data-stage instruction
- im_sel_D  in  1  data-stage operand A is the immediate, not a register
- pc_en  out  1  PC advance enable
- ir_en  out  1  instruction-register load enable
- ir_flush  out  1  instruction-register clears to NOP-equivalent controls on next edge
- dr_bubble  out  1  data register loads zeroed controls (no write, no read, no jump)
- pipe_en  out  1  data/execution registers and all register/memory write enables are gated by this
- running  out  1  registered; 1 in RUN, STALL, FLUSH
- state  out  3  current FSM state, for debug LEDs
- retired  out  CNT_W  instructions that completed writeback

## Operation
- States: LOAD=0, RUN=1, STALL=2, FLUSH=3, STEP_WAIT=4.
- hazard = reg_write_E & v_E & ((a_addr_D==c_addr_E & !im_sel_D) | b_addr_D==c_addr_E).
- Outputs are combinational from state and current inputs:
  - LOAD and STEP_WAIT: pc_en=ir_en=pipe_en=0, ir_flush=0, dr_bubble=0. In LOAD, ir_flush=1 and dr_bubble=1.
  - RUN, no event: pc_en=ir_en=pipe_en=1, ir_flush=0, dr_bubble=0.
  - RUN with jump_en_E & v_E: pc_en=1, ir_en=1, ir_flush=1, dr_bubble=1, pipe_en=1.
  - RUN with hazard and no jump: pc_en=0, ir_en=0, dr_bubble=1, pipe_en=1.
- Jump has priority over hazard; the hazarding instruction is flushed anyway.
- Transitions:
  - LOAD→RUN when load_done=1.
  - RUN→FLUSH on a jump.
  - RUN→STALL on a hazard.
  - STALL→RUN and FLUSH→RUN unconditionally, after one cycle.
  - From RUN, STALL or FLUSH, if step_mode=1 after the advancing cycle, go to STEP_WAIT.
  - STEP_WAIT→RUN on a synchronised rising edge of step_btn; exactly one advance cycle follows.
  - Any state→LOAD when load_done=0; this clears valid bits.
- STALL and FLUSH behave as RUN-no-event for their own cycle, with hazard and jump rechecked.
- Valid tracking: shift register v_D, v_E, v_W advances when pipe_en=1.
  - v_D takes 1 if ir_en & !ir_flush.
  - v_E takes v_D & !dr_bubble.
  - v_W takes v_E.
- retired increments when pipe_en & v_W, and wraps at 2^CNT_W−1 → 0.

## Timing
- Reset: state=LOAD, running=0, retired=0, v_*=0, synchroniser flops 0. Combinational outputs therefore reset to pc_en=0, ir_en=0, ir_flush=1, dr_bubble=1, pipe_en=0.
- Hazard costs exactly 1 cycle. Jump costs 2 issue slots: the D and E bubbles.
- step_btn press to first advance cycle: 3 CLK edges (2 synchroniser flops plus edge register).
- Holding the button produces exactly one step. A press while step_mode=0 is ignored.
- load_done dropping mid-run takes effect on the next edge, with outputs already at LOAD values in that cycle.

## Structure
- Shared package processor_pkg holds:
  - state encodings (seq_state_t)
  - REG_ADDR_W and PC_W constants
  - NOP control-field constant used by ir_flush/dr_bubble
- Sub-module btn_edge_sync: 2-flop synchroniser plus rising-edge pulse, with asynchronous active-low reset.
- Hazard comparator stays inline.

## Test plan
- Reset, then load_done=0 for 5 cycles → state=0, pc_en=0, ir_flush=1. Set load_done=1 → state=1, pc_en=1 next cycle.
- Set reg_write_E=1, v_E=1, c_addr_E=3, a_addr_D=3, im_sel_D=0 → one cycle with pc_en=0, dr_bubble=1, state=2, then back to RUN. Same case with im_sel_D=1 and b_addr_D=5 → no stall.
- jump_en_E=1 together with hazard → ir_flush=1, dr_bubble=1, pc_en=1, state=3. retired increases by 2 less than cycles elapsed over the window.
- Program of 10 straight-line instructions with no hazards → retired=10 three cycles after the last fetch.
- step_mode=1, pulse step_btn 4 times with long holds → exactly 4 advance cycles, each starting 3 edges after its press.
- Drop load_done mid-STALL → state=0 on the next edge and v_*=0. Async RST_N low mid-FLUSH → all registered outputs cleared immediately.

Source files
------------

// File: rtl/processor_pkg.sv
// processor_pkg: shared BRISC pipeline constants, sequencer states and NOP control word
package processor_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int PC_W = 8;
  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    RUN       = 3'd1,
    STALL     = 3'd2,
    FLUSH     = 3'd3,
    STEP_WAIT = 3'd4
  } seq_state_t;
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic jump;
    logic rd_a;
    logic rd_b;
  } ctrl_t;
  localparam ctrl_t NOP_CTRL = '0;
endpackage

// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if: datapath-to-sequencer control bundle
interface pipeline_sequencer_if #(
  parameter int REG_ADDR_W = processor_pkg::REG_ADDR_W,
  parameter int CNT_W = 16
);
  logic load_done, step_mode, step_btn, jump_en_E, reg_write_E, im_sel_D;
  logic [REG_ADDR_W-1:0] c_addr_E, a_addr_D, b_addr_D;
  logic pc_en, ir_en, ir_flush, dr_bubble, pipe_en, running;
  logic [2:0] state;
  logic [CNT_W-1:0] retired;
  modport master (
    output load_done, step_mode, step_btn, jump_en_E, reg_write_E, im_sel_D,
           c_addr_E, a_addr_D, b_addr_D,
    input  pc_en, ir_en, ir_flush, dr_bubble, pipe_en, running, state, retired
  );
  modport slave (
    input  load_done, step_mode, step_btn, jump_en_E, reg_write_E, im_sel_D,
           c_addr_E, a_addr_D, b_addr_D,
    output pc_en, ir_en, ir_flush, dr_bubble, pipe_en, running, state, retired
  );
endinterface

// File: rtl/pipeline_sequencer_btn_edge_sync.sv
// btn_edge_sync: two-flop synchroniser with a rising-edge pulse from a third history flop
module btn_edge_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn,
  output logic rise
);
  logic [2:0] sync_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) sync_q <= '0;
    else sync_q <= {sync_q[1:0], btn};
  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: load gating, hazard stall, jump flush, single-step and retire count for BRISC
module pipeline_sequencer
  import processor_pkg::*;
#(
  parameter int REG_ADDR_W = processor_pkg::REG_ADDR_W,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RST_N,
  pipeline_sequencer_if.slave bus
);
  seq_state_t state_q, state_d;
  logic v_d, v_e, v_w, rise, jump, hazard, live, load_out, running_q;
  logic pc_en, ir_en, ir_flush, dr_bubble, pipe_en;
  logic [REG_ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [CNT_W-1:0] retired_q;
  assign a_addr = bus.a_addr_D;
  assign b_addr = bus.b_addr_D;
  assign c_addr = bus.c_addr_E;
  btn_edge_sync u_sync (.CLK(CLK), .RST_N(RST_N), .btn(bus.step_btn), .rise(rise));
  assign jump = bus.jump_en_E & v_e;
  assign hazard = bus.reg_write_E & v_e & (((a_addr == c_addr) & !bus.im_sel_D) | (b_addr == c_addr));
  assign live = bus.load_done & (state_q inside {RUN, STALL, FLUSH});
  assign load_out = !bus.load_done | (state_q == LOAD);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= LOAD;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      running_q <= state_d inside {RUN, STALL, FLUSH};
    end
  always_comb
    state_d = !bus.load_done ? LOAD :
              state_q == LOAD ? RUN :
              state_q == STEP_WAIT ? ((rise | !bus.step_mode) ? RUN : STEP_WAIT) :
              jump ? FLUSH : hazard ? STALL : bus.step_mode ? STEP_WAIT : RUN;
  // jump wins over hazard: the hazarding instruction is being flushed anyway
  always_comb begin
    pc_en = live & (jump | !hazard);
    ir_en = pc_en;
    ir_flush = load_out | (live & jump);
    dr_bubble = load_out | (live & (jump | hazard));
    pipe_en = live;
  end
  // a stalled IR keeps its instruction, so v_d holds when ir_en is low
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      {v_d, v_e, v_w} <= '0;
      retired_q <= '0;
    end else if (!bus.load_done) begin
      {v_d, v_e, v_w} <= '0;
    end else if (pipe_en) begin
      v_d <= !ir_flush & (ir_en | v_d);
      v_e <= v_d & !dr_bubble;
      v_w <= v_e;
      retired_q <= retired_q + CNT_W'(v_w);
    end
  assign bus.pc_en = pc_en;
  assign bus.ir_en = ir_en;
  assign bus.ir_flush = ir_flush;
  assign bus.dr_bubble = dr_bubble;
  assign bus.pipe_en = pipe_en;
  assign bus.running = running_q;
  assign bus.state = state_q;
  assign bus.retired = retired_q;
endmodule
